cache_core_req_split_sched: RTL and testbench

- Accepts one multi-lane core request batch and serializes it into bank issues.
- Each bank receives at most one request per cycle. When several lanes map to the same bank, they are issued over successive cycles.
- Sits between the core request port and the per-bank request queues. It is the sequencing layer above bank selection and turns bank conflicts into stall cycles instead of dropped requests.

---
 rtl/cache_core_req_split_sched_if.sv | 28 ++
 rtl/cache_core_req_split_sched.sv | 99 +++++++++
 tb/tb_cache_core_req_split_sched.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_core_req_split_sched_if.sv
// Handshake bundle between the core request port, the split scheduler and the per-bank request queues.
// The slave modport is the scheduler's view; the master modport is the surrounding environment.
interface cache_core_req_split_sched_if #(
  parameter int NUM_BANKS       = 4,
  parameter int NUM_REQUESTS    = 4,
  parameter int WORD_ADDR_WIDTH = 30
);
  localparam int REQ_IDX_W = (NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1;

  logic [NUM_REQUESTS-1:0]                 core_req_valid;
  logic [NUM_REQUESTS*WORD_ADDR_WIDTH-1:0] core_req_addr;
  logic                                    core_req_ready;
  logic [NUM_BANKS-1:0]                    per_bank_valid;
  logic [NUM_BANKS*REQ_IDX_W-1:0]          per_bank_req_idx;
  logic [NUM_BANKS*WORD_ADDR_WIDTH-1:0]    per_bank_addr;
  logic [NUM_BANKS-1:0]                    per_bank_ready;
  logic                                    busy;

  modport master (
    output core_req_valid, core_req_addr, per_bank_ready,
    input  core_req_ready, per_bank_valid, per_bank_req_idx, per_bank_addr, busy
  );

  modport slave (
    input  core_req_valid, core_req_addr, per_bank_ready,
    output core_req_ready, per_bank_valid, per_bank_req_idx, per_bank_addr, busy
  );
endinterface

// File: rtl/cache_core_req_split_sched.sv
// Serializes a multi-lane core request batch into per-bank issues, one request per bank per cycle.
// Optional macro CACHE_SPLIT_SCHED_BYPASS_EN lets a new batch be accepted in the cycle the last lanes drain.
module cache_core_req_split_sched #(
  parameter int NUM_BANKS       = 4,
  parameter int NUM_REQUESTS    = 4,
  parameter int WORD_ADDR_WIDTH = 30,
  parameter int BANK_SEL_LSB    = 2
) (
  input logic                         clk,
  input logic                         reset,
  cache_core_req_split_sched_if.slave bus
);

  localparam int BANK_SEL_BITS = $clog2(NUM_BANKS);
  localparam int BSB_W         = (BANK_SEL_BITS > 0) ? BANK_SEL_BITS : 1;
  localparam int REQ_IDX_W     = (NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                     state;
  logic [NUM_REQUESTS-1:0]    pending;
  logic [WORD_ADDR_WIDTH-1:0] addr_q [NUM_REQUESTS];

  logic [NUM_BANKS-1:0]       bank_valid;
  logic [REQ_IDX_W-1:0]       bank_idx [NUM_BANKS];
  logic [NUM_REQUESTS-1:0]    cleared;
  logic [NUM_REQUESTS-1:0]    pending_next;
  logic                       all_done;
  logic                       capture;

  function automatic logic [BSB_W-1:0] bank_of(input logic [WORD_ADDR_WIDTH-1:0] a);
    if (NUM_BANKS == 1) return '0;
    else                return a[BANK_SEL_LSB +: BSB_W];
  endfunction

  always_comb begin
    bank_valid = '0;
    cleared    = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_idx[b] = '0;
      // NOTE: blocking assignments in combinational logic; scanning lanes downwards
      // means the last match written is the lowest index, giving fixed priority.
      for (int i = NUM_REQUESTS - 1; i >= 0; i--) begin
        if (state == ISSUE && pending[i] && bank_of(addr_q[i]) == BSB_W'(b)) begin
          bank_valid[b] = 1'b1;
          bank_idx[b]   = REQ_IDX_W'(i);
        end
      end
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int i = 0; i < NUM_REQUESTS; i++) begin
        if (bank_valid[b] && bus.per_bank_ready[b] && bank_idx[b] == REQ_IDX_W'(i))
          cleared[i] = 1'b1;
      end
    end
    pending_next = pending & ~cleared;
  end

  assign all_done = (state == ISSUE) && (pending_next == '0);

`ifdef CACHE_SPLIT_SCHED_BYPASS_EN
  assign bus.core_req_ready = (state == IDLE) || all_done;
`else
  assign bus.core_req_ready = (state == IDLE);
`endif

  assign capture  = bus.core_req_ready && (|bus.core_req_valid);
  assign bus.busy = (state == ISSUE);

  // Bank outputs depend only on registered state, never on the current inputs.
  always_comb begin
    bus.per_bank_valid   = bank_valid;
    bus.per_bank_req_idx = '0;
    bus.per_bank_addr    = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bus.per_bank_req_idx[b*REQ_IDX_W +: REQ_IDX_W] = bank_idx[b];
      if (bank_valid[b])
        bus.per_bank_addr[b*WORD_ADDR_WIDTH +: WORD_ADDR_WIDTH] = addr_q[bank_idx[b]];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pending <= '0;
      // NOTE: the address store is reset too, so nothing from a discarded batch survives reset.
      for (int i = 0; i < NUM_REQUESTS; i++) addr_q[i] <= '0;
    end else if (capture) begin
      state   <= ISSUE;
      pending <= bus.core_req_valid;
      for (int i = 0; i < NUM_REQUESTS; i++)
        addr_q[i] <= bus.core_req_addr[i*WORD_ADDR_WIDTH +: WORD_ADDR_WIDTH];
    end else if (state == ISSUE) begin
      pending <= pending_next;
      if (all_done) state <= IDLE;
    end
  end

endmodule

// File: tb/tb_cache_core_req_split_sched.sv
// Directed self-checking bench for cache_core_req_split_sched with default parameters.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_cache_core_req_split_sched;

  localparam int W  = 30;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cache_core_req_split_sched_if bus ();

  cache_core_req_split_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [W-1:0] mk_addr(input int bank, input int tag);
    return W'((tag << 4) | (bank << 2) | (tag & 3));
  endfunction

  function automatic logic [IW-1:0] get_idx(input int b);
    return bus.per_bank_req_idx[b*IW +: IW];
  endfunction

  function automatic logic [W-1:0] get_addr(input int b);
    return bus.per_bank_addr[b*W +: W];
  endfunction

  task automatic set_lane(input int i, input logic [W-1:0] a);
    bus.core_req_addr[i*W +: W] = a;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.core_req_valid = '0;
    bus.core_req_addr  = '0;
    bus.per_bank_ready = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.core_req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.per_bank_valid !== 4'b0000 ||
        bus.per_bank_req_idx !== '0 || bus.per_bank_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b busy=%b valid=%b idx=%h addr=%h, want ready=1 and all else 0",
               bus.core_req_ready, bus.busy, bus.per_bank_valid, bus.per_bank_req_idx, bus.per_bank_addr);
    end
    reset = 1'b1;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (bus.core_req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.per_bank_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL after_reset: ready=%b busy=%b valid=%b, want 1 0 0000",
               bus.core_req_ready, bus.busy, bus.per_bank_valid);
    end
    next_cycle();
  endtask

  task automatic test_conflict_free();
    bus.core_req_valid = 4'b1111;
    bus.per_bank_ready = 4'b1111;
    for (int b = 0; b < 4; b++) set_lane(b, mk_addr(b, 'h20 + b));
    @(negedge clk);
    n_checks++;
    if (bus.core_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cf_accept: core_req_ready=%b want 1", bus.core_req_ready);
    end
    next_cycle();
    bus.core_req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (bus.per_bank_valid !== 4'b1111) begin
      n_fail++;
      $display("FAIL cf_issue_valid: per_bank_valid=%b want 1111", bus.per_bank_valid);
    end
    for (int b = 0; b < 4; b++) begin
      n_checks++;
      if (get_idx(b) !== IW'(b) || get_addr(b) !== mk_addr(b, 'h20 + b)) begin
        n_fail++;
        $display("FAIL cf_issue_bank%0d: idx=%0d addr=%h want idx=%0d addr=%h",
                 b, get_idx(b), get_addr(b), b, mk_addr(b, 'h20 + b));
      end
    end
    n_checks++;
`ifdef CACHE_SPLIT_SCHED_BYPASS_EN
    if (bus.core_req_ready !== 1'b1) begin
`else
    if (bus.core_req_ready !== 1'b0) begin
`endif
      n_fail++;
      $display("FAIL cf_ready_during_issue: core_req_ready=%b", bus.core_req_ready);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (bus.core_req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.per_bank_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL cf_done: ready=%b busy=%b valid=%b want 1 0 0000",
               bus.core_req_ready, bus.busy, bus.per_bank_valid);
    end
    next_cycle();
  endtask

  task automatic test_same_bank();
    bus.core_req_valid = 4'b1111;
    bus.per_bank_ready = 4'b1111;
    for (int i = 0; i < 4; i++) set_lane(i, mk_addr(2, 'h30 + i));
    @(negedge clk);
    next_cycle();
    bus.core_req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.per_bank_valid !== 4'b0100 || get_idx(2) !== IW'(k) || get_addr(2) !== mk_addr(2, 'h30 + k)) begin
        n_fail++;
        $display("FAIL same_bank_cycle%0d: valid=%b idx=%0d addr=%h want 0100 idx=%0d addr=%h",
                 k + 1, bus.per_bank_valid, get_idx(2), get_addr(2), k, mk_addr(2, 'h30 + k));
      end
      next_cycle();
    end
    @(negedge clk);
    n_checks++;
    if (bus.core_req_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL same_bank_done: ready=%b busy=%b want 1 0", bus.core_req_ready, bus.busy);
    end
    next_cycle();
  endtask

  task automatic test_backpressure();
    bus.core_req_valid = 4'b1111;
    bus.per_bank_ready = 4'b1101;
    set_lane(0, mk_addr(1, 'h50));
    set_lane(1, mk_addr(1, 'h51));
    set_lane(2, mk_addr(3, 'h52));
    set_lane(3, mk_addr(0, 'h53));
    @(negedge clk);
    next_cycle();
    bus.core_req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (bus.per_bank_valid !== 4'b1011 || get_idx(0) !== 2'd3 || get_idx(1) !== 2'd0 ||
        get_idx(3) !== 2'd2 || get_addr(1) !== mk_addr(1, 'h50)) begin
      n_fail++;
      $display("FAIL bp_cycle1: valid=%b idx0=%0d idx1=%0d idx3=%0d addr1=%h want 1011 3 0 2 %h",
               bus.per_bank_valid, get_idx(0), get_idx(1), get_idx(3), get_addr(1), mk_addr(1, 'h50));
    end
    next_cycle();
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.per_bank_valid !== 4'b0010 || get_idx(1) !== 2'd0 || get_addr(1) !== mk_addr(1, 'h50)) begin
        n_fail++;
        $display("FAIL bp_hold_cycle%0d: valid=%b idx1=%0d addr1=%h want 0010 0 %h",
                 c, bus.per_bank_valid, get_idx(1), get_addr(1), mk_addr(1, 'h50));
      end
      next_cycle();
    end
    bus.per_bank_ready = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.per_bank_valid !== 4'b0010 || get_idx(1) !== IW'(k) || get_addr(1) !== mk_addr(1, 'h50 + k)) begin
        n_fail++;
        $display("FAIL bp_drain_cycle%0d: valid=%b idx1=%0d addr1=%h want 0010 %0d %h",
                 k + 4, bus.per_bank_valid, get_idx(1), get_addr(1), k, mk_addr(1, 'h50 + k));
      end
      next_cycle();
    end
    @(negedge clk);
    n_checks++;
    if (bus.core_req_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_done: ready=%b busy=%b want 1 0", bus.core_req_ready, bus.busy);
    end
    next_cycle();
  endtask

  task automatic test_sparse_valid();
    bus.core_req_valid = 4'b0101;
    bus.per_bank_ready = 4'b1111;
    set_lane(0, mk_addr(0, 'h60));
    set_lane(1, mk_addr(1, 'h61));
    set_lane(2, mk_addr(0, 'h62));
    set_lane(3, mk_addr(3, 'h63));
    @(negedge clk);
    next_cycle();
    bus.core_req_valid = '0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.per_bank_valid !== 4'b0001 || get_idx(0) !== IW'(2 * k) || get_addr(0) !== mk_addr(0, 'h60 + 2 * k)) begin
        n_fail++;
        $display("FAIL sparse_cycle%0d: valid=%b idx0=%0d addr0=%h want 0001 %0d %h",
                 k + 1, bus.per_bank_valid, get_idx(0), get_addr(0), 2 * k, mk_addr(0, 'h60 + 2 * k));
      end
      next_cycle();
    end
    @(negedge clk);
    n_checks++;
    if (bus.per_bank_valid !== 4'b0000 || bus.busy !== 1'b0 || bus.core_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL sparse_done: valid=%b busy=%b ready=%b want 0000 0 1",
               bus.per_bank_valid, bus.busy, bus.core_req_ready);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_issue();
    bus.core_req_valid = 4'b1111;
    bus.per_bank_ready = 4'b0011;
    for (int b = 0; b < 4; b++) set_lane(b, mk_addr(b, 'h70 + b));
    @(negedge clk);
    next_cycle();
    bus.core_req_valid = '0;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (bus.per_bank_valid !== 4'b1100 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: valid=%b busy=%b want 1100 1", bus.per_bank_valid, bus.busy);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (bus.per_bank_valid !== 4'b0000 || bus.busy !== 1'b0 || bus.core_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_immediate: valid=%b busy=%b ready=%b want 0000 0 1",
               bus.per_bank_valid, bus.busy, bus.core_req_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    bus.per_bank_ready = 4'b1111;
    next_cycle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.per_bank_valid !== 4'b0000 || bus.busy !== 1'b0 || bus.core_req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_residual%0d: valid=%b busy=%b ready=%b want 0000 0 1",
                 c, bus.per_bank_valid, bus.busy, bus.core_req_ready);
      end
      next_cycle();
    end
  endtask

  task automatic drive_batch(input int k);
    bus.core_req_valid = 4'b1111;
    for (int b = 0; b < 4; b++) set_lane(b, mk_addr(b, 'h80 + 16 * k + b));
  endtask

  task automatic test_back_to_back();
    int acc [3];
    int iss [3];
    int k = 0;
    int n = 0;
    int stalls = 0;
    int exp_acc [3];
    int exp_iss [3];
    int exp_stalls;
    bit addr_ok;
`ifdef CACHE_SPLIT_SCHED_BYPASS_EN
    exp_acc = '{0, 1, 2};
    exp_iss = '{1, 2, 3};
    exp_stalls = 0;
`else
    exp_acc = '{0, 2, 4};
    exp_iss = '{1, 3, 5};
    exp_stalls = 2;
`endif
    for (int i = 0; i < 3; i++) begin
      acc[i] = -1;
      iss[i] = -1;
    end
    bus.per_bank_ready = 4'b1111;
    drive_batch(0);
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (bus.per_bank_valid !== 4'b0000) begin
        addr_ok = 1'b1;
        for (int b = 0; b < 4; b++)
          if (get_addr(b) !== mk_addr(b, 'h80 + 16 * n + b)) addr_ok = 1'b0;
        n_checks++;
        if (bus.per_bank_valid !== 4'b1111 || !addr_ok) begin
          n_fail++;
          $display("FAIL b2b_issue%0d: valid=%b addr=%h want 1111 with batch %0d addresses",
                   n, bus.per_bank_valid, bus.per_bank_addr, n);
        end
        if (n < 3) iss[n] = cyc;
        n++;
      end
      if (k < 3) begin
        if (bus.core_req_ready === 1'b1) begin
          acc[k] = cyc;
          k++;
        end else begin
          stalls++;
        end
      end
      next_cycle();
      if (k < 3) drive_batch(k);
      else bus.core_req_valid = '0;
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (acc[i] !== exp_acc[i] || iss[i] !== exp_iss[i]) begin
        n_fail++;
        $display("FAIL b2b_batch%0d: accepted cycle %0d issued cycle %0d, want %0d and %0d",
                 i, acc[i], iss[i], exp_acc[i], exp_iss[i]);
      end
    end
    n_checks++;
    if (stalls !== exp_stalls || n !== 3) begin
      n_fail++;
      $display("FAIL b2b_stalls: stalls=%0d issues=%0d want %0d and 3", stalls, n, exp_stalls);
    end
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.core_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done: busy=%b ready=%b want 0 1", bus.busy, bus.core_req_ready);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_conflict_free();
    test_same_bank();
    test_backpressure();
    test_sparse_valid();
    test_reset_mid_issue();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
